// File: rtl/mux_arb_n_pkg.sv
// Shared constants and helpers for the N-input registered stream mux.
package mux_arb_n_pkg;

    localparam int unsigned MUX_MODE_FIXED = 0;
    localparam int unsigned MUX_MODE_RR    = 1;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Producer-side and consumer-side handshake bundle for mux_arb_n.
interface mux_arb_n_if
    import mux_arb_n_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = sel_width(N)
);

    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            out_ready;

    // Mux side.
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    // Producers/consumer side.
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// Rotating-priority picker: first requester at or after the pointer, wrapping.
module mux_arb_n_rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] grant_o,
    output logic            grant_valid_o
);

    // Scan ptr..N-1 first, then 0..ptr-1, taking the first request seen.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!grant_valid_o && req_i[i] && (i >= 32'(ptr_i))) begin
                grant_valid_o = 1'b1;
                grant_o       = SELW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!grant_valid_o && req_i[i] && (i < 32'(ptr_i))) begin
                grant_valid_o = 1'b1;
                grant_o       = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-input W-bit stream mux with registered output; fixed-select or round-robin.
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned MODE = MUX_MODE_FIXED,
    parameter int unsigned SELW = sel_width(N)
) (
    input  logic        clk,
    input  logic        rst,
    mux_arb_n_if.slave  bus
);

    logic            load_en;
    logic [SELW-1:0] grant;
    logic            grant_valid;
    logic [N-1:0]    ready;
    logic            xfer;
    logic [W-1:0]    pick_data;

    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [SELW-1:0] out_ch_q;
    logic [SELW-1:0] rr_ptr_q;
    logic [SELW-1:0] rr_ptr_d;

    // The output register can take a new item when empty or being drained.
    assign load_en = !out_valid_q || bus.out_ready;

    if (MODE == MUX_MODE_RR) begin : g_rr
        mux_arb_n_rr_pick #(
            .N    (N),
            .SELW (SELW)
        ) u_pick (
            .req_i         (bus.in_valid),
            .ptr_i         (rr_ptr_q),
            .grant_o       (grant),
            .grant_valid_o (grant_valid)
        );
    end else begin : g_fixed
        // Fixed select; an out-of-range sel matches no channel and grants nothing.
        always_comb begin
            grant       = bus.sel;
            grant_valid = 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                if (32'(bus.sel) == i) begin
                    grant_valid = bus.in_valid[i];
                end
            end
        end
    end

    // One-hot accept for the granted channel, suppressed during reset.
    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!rst && load_en && grant_valid && (32'(grant) == i)) begin
                ready[i] = 1'b1;
            end
        end
    end

    assign xfer = |(bus.in_valid & ready);

    // Data slice of the granted channel.
    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(grant) == i) begin
                pick_data = bus.in_data[i*W +: W];
            end
        end
    end

    // Round-robin pointer moves just past the channel that transferred.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((MODE == MUX_MODE_RR) && xfer) begin
            rr_ptr_d = (32'(grant) == N - 1) ? '0 : grant + SELW'(1);
        end
    end

    // Output register and pointer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (load_en) begin
                if (xfer) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= pick_data;
                    out_ch_q    <= grant;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: one fixed-select instance and one round-robin instance.
module tb_mux_arb_n;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [31:0] idata [2];
    logic [3:0]  iv    [2];
    logic [1:0]  isel  [2];
    logic        ordy  [2];

    mux_arb_n_if #(.N(4), .W(8), .SELW(2)) a0 ();
    mux_arb_n_if #(.N(4), .W(8), .SELW(2)) a1 ();

    assign a0.in_data   = idata[0];
    assign a0.in_valid  = iv[0];
    assign a0.sel       = isel[0];
    assign a0.out_ready = ordy[0];
    assign a1.in_data   = idata[1];
    assign a1.in_valid  = iv[1];
    assign a1.sel       = isel[1];
    assign a1.out_ready = ordy[1];

    mux_arb_n #(.N(4), .W(8), .MODE(0), .SELW(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (a0)
    );

    mux_arb_n #(.N(4), .W(8), .MODE(1), .SELW(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (a1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the output register and pointer should hold.
    bit          m_valid [2];
    logic [7:0]  m_data  [2];
    int          m_ch    [2];
    int          m_ptr   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel the rules say should be chosen now, or -1 for none.
    function automatic int grant_of(input int d);
        if (d == 0) begin
            return iv[0][isel[0]] ? int'(isel[0]) : -1;
        end
        for (int k = 0; k < N; k++) begin
            if (iv[1][(m_ptr[1] + k) % N]) return (m_ptr[1] + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int d);
        int g;
        g = grant_of(d);
        if (rst || (m_valid[d] && !ordy[d]) || g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    task automatic pre();
        #2;
        chk("ready0", a0.in_ready, exp_ready(0));
        chk("ready1", a1.in_ready, exp_ready(1));
    endtask

    task automatic post();
        int g [2];
        for (int d = 0; d < 2; d++) g[d] = grant_of(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_valid[d] = 0;
                m_data[d]  = 8'h00;
                m_ch[d]    = 0;
                m_ptr[d]   = 0;
            end else if (!m_valid[d] || ordy[d]) begin
                if (g[d] >= 0) begin
                    m_valid[d] = 1;
                    m_data[d]  = idata[d][g[d]*8 +: 8];
                    m_ch[d]    = g[d];
                    if (d == 1) m_ptr[1] = (g[d] + 1) % N;
                end else begin
                    m_valid[d] = 0;
                end
            end
        end
        #1;
        chk("valid0", a0.out_valid, m_valid[0]);
        chk("data0",  a0.out_data,  m_data[0]);
        chk("ch0",    a0.out_ch,    m_ch[0]);
        chk("valid1", a1.out_valid, m_valid[1]);
        chk("data1",  a1.out_data,  m_data[1]);
        chk("ch1",    a1.out_ch,    m_ch[1]);
    endtask

    task automatic cycle();
        pre();
        post();
    endtask

    initial begin
        logic [31:0] held;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0;
            m_data[d]  = 8'h00;
            m_ch[d]    = 0;
            m_ptr[d]   = 0;
            ordy[d]    = 1'b1;
            iv[d]      = 4'b1111;
            isel[d]    = 2'd0;
        end
        idata[0] = $urandom;
        idata[1] = 32'h13121110;
        rst      = 1'b1;

        // Reset held for two cycles with every channel requesting.
        repeat (2) begin
            pre();
            chk("rst_ready", a1.in_ready, 4'b0000);
            post();
            chk("rst_valid", a1.out_valid, 1'b0);
            chk("rst_data",  a1.out_data,  8'h00);
            chk("rst_ch",    a1.out_ch,    2'd0);
        end
        rst = 1'b0;

        // Round-robin fairness from a fresh pointer.
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("fair_ch",    a1.out_ch,    i % 4);
            chk("fair_data",  a1.out_data,  8'h10 + (i % 4));
            chk("fair_valid", a1.out_valid, 1'b1);
        end

        // Fixed select on channel 2, then a select whose channel is idle.
        iv[1]    = 4'b0000;
        isel[0]  = 2'd2;
        iv[0]    = 4'b0100;
        idata[0] = $urandom;
        idata[0][23:16] = 8'hA5;
        pre();
        chk("sel2_ready", a0.in_ready, 4'b0100);
        post();
        chk("sel2_valid", a0.out_valid, 1'b1);
        chk("sel2_data",  a0.out_data,  8'hA5);
        chk("sel2_ch",    a0.out_ch,    2'd2);
        isel[0] = 2'd1;
        pre();
        chk("sel1_ready", a0.in_ready, 4'b0000);
        post();
        chk("sel1_valid", a0.out_valid, 1'b0);

        // Backpressure: hold 8'h3C for five stalled cycles, then drain with no bubble.
        iv[1]    = 4'b1111;
        idata[1] = $urandom;
        idata[1][23:16] = 8'h3C;
        cycle();
        chk("bp_load", a1.out_data, 8'h3C);
        ordy[1] = 1'b0;
        repeat (5) begin
            idata[1] = $urandom;
            iv[1]    = 4'($urandom_range(1, 15));
            pre();
            chk("bp_ready", a1.in_ready, 4'b0000);
            post();
            chk("bp_data", a1.out_data, 8'h3C);
            chk("bp_ch",   a1.out_ch,   2'd2);
        end
        ordy[1]  = 1'b1;
        iv[1]    = 4'b1111;
        idata[1] = $urandom;
        held     = idata[1];
        pre();
        chk("bp_release_ready", a1.in_ready, 4'b1000);
        post();
        chk("bp_next_valid", a1.out_valid, 1'b1);
        chk("bp_next_ch",    a1.out_ch,    2'd3);
        chk("bp_next_data",  a1.out_data,  held[31:24]);

        // Skip and wrap: after ch2, only ch0/ch1 request; ch3 must never win.
        iv[1] = 4'b0100;
        cycle();
        chk("wrap_ch2", a1.out_ch, 2'd2);
        iv[1] = 4'b0011;
        cycle();
        chk("wrap_ch0a", a1.out_ch, 2'd0);
        cycle();
        chk("wrap_ch1", a1.out_ch, 2'd1);
        cycle();
        chk("wrap_ch0b", a1.out_ch, 2'd0);

        // Reset in the middle of a stall with the pointer at 2.
        iv[1] = 4'b0010;
        cycle();
        chk("mid_ch1", a1.out_ch, 2'd1);
        ordy[1] = 1'b0;
        iv[1]   = 4'b1111;
        cycle();
        chk("mid_stall_valid", a1.out_valid, 1'b1);
        rst = 1'b1;
        pre();
        chk("mid_rst_ready", a1.in_ready, 4'b0000);
        post();
        chk("mid_rst_valid", a1.out_valid, 1'b0);
        chk("mid_rst_data",  a1.out_data,  8'h00);
        rst     = 1'b0;
        ordy[1] = 1'b1;
        cycle();
        chk("mid_restart_ch",    a1.out_ch,    2'd0);
        chk("mid_restart_valid", a1.out_valid, 1'b1);

        // Random traffic on both instances, with occasional reset.
        for (int t = 0; t < 300; t++) begin
            for (int d = 0; d < 2; d++) begin
                iv[d]    = 4'($urandom);
                idata[d] = $urandom;
                isel[d]  = 2'($urandom);
                ordy[d]  = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
